bus_arbiter: RTL and testbench

- Central arbiter and sequencer for the shared 32-bit data / 16-bit address bus used by the memory-side bus controllers.
- Collects BR from up to NREQ master controllers and issues a one-hot BG using round-robin priority.
- Decodes the granted master's address into a one-cycle DEST pulse to the target slave controller.
- Routes the addressed slave's ACK back to the owning master.

---
 rtl/bus_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// bus_arbiter
//   Round-robin arbiter and sequencer for the shared 32-bit data / 16-bit
//   address bus. Grants one master at a time, walks it through
//   GRANT -> ADDR -> XFER -> RELEASE, decodes A[15:14] into a one-cycle DEST
//   pulse to the addressed slave, and routes that slave's ACK back to the owner.
//
//   Optional watchdog: define ARB_TIMEOUT_EN to bound ownership at TIMEOUT
//   cycles. A master that times out is locked out until it drops BR for a cycle.
//
// Ports
//   BUS_CLK      bus clock, rising edge
//   RST          asynchronous active-high reset
//   BR[NREQ]     bus request per master
//   BG[NREQ]     bus grant, one-hot or zero
//   A[16]        address driven by the current master
//   DEST[4]      one-cycle one-hot slave select (slave = A[15:14])
//   ACK_SLV[4]   ACK from each slave
//   ACK_MSTR     ACK routed to the owning master (combinational)
//   BUSY         bus owned (state != IDLE)
//   OWNER[3]     current or last owner index
//   TIMEOUT_ERR  one-cycle watchdog pulse (0 without ARB_TIMEOUT_EN)
module bus_arbiter #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            BUS_CLK,
    input  logic            RST,
    input  logic [NREQ-1:0] BR,
    output logic [NREQ-1:0] BG,
    input  logic [15:0]     A,
    output logic [3:0]      DEST,
    input  logic [3:0]      ACK_SLV,
    output logic [NREQ-1:0] ACK_MSTR,
    output logic            BUSY,
    output logic [2:0]      OWNER,
    output logic            TIMEOUT_ERR
);

    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        GRANT   = 5'b00010,
        ADDR    = 5'b00100,
        XFER    = 5'b01000,
        RELEASE = 5'b10000
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      owner_nxt, rr_last, rr_last_nxt, win_idx;
    logic [NREQ-1:0] own_oh, own_oh_nxt, bg_nxt, win_oh, req_eff;
    logic [3:0]      dest_nxt;
    logic [1:0]      dest_idx, dest_idx_nxt;
    logic            win_found, owner_req, expired, ack_sel;
    logic            unused_addr;
    int              best_d;

    // own_oh mirrors OWNER as a mask so BR[OWNER] needs no variable index.
    assign owner_req   = |(BR & own_oh);
    assign unused_addr = ^A[13:0];

    // Round-robin pick: the requester at the smallest circular distance
    // past rr_last wins.
    always_comb begin
        best_d    = NREQ;
        win_idx   = '0;
        win_found = |req_eff;
        for (int i = 0; i < NREQ; i++) begin
            if (req_eff[i] && ((i + 2*NREQ - 1 - int'(rr_last)) % NREQ) < best_d) begin
                best_d  = (i + 2*NREQ - 1 - int'(rr_last)) % NREQ;
                win_idx = 3'(i);
            end
        end
        win_oh = '0;
        for (int i = 0; i < NREQ; i++) win_oh[i] = (win_idx == 3'(i));
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0]   tcnt, tcnt_nxt;
    logic [NREQ-1:0] blocked, blocked_nxt;
    logic            terr, owned;

    assign owned       = (state == GRANT) || (state == ADDR) || (state == XFER);
    assign req_eff     = BR & ~blocked;
    assign expired     = owned && owner_req && (tcnt == CW'(TIMEOUT - 1));
    assign TIMEOUT_ERR = terr;

    always_comb begin
        tcnt_nxt    = tcnt;
        // A lockout lifts as soon as the master is seen with BR low.
        blocked_nxt = blocked & BR;
        if (state == IDLE)  tcnt_nxt = '0;  // GRANT is only entered from IDLE
        else if (owned)     tcnt_nxt = tcnt + CW'(1);
        if (expired)        blocked_nxt = blocked_nxt | own_oh;
    end

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            tcnt    <= '0;
            blocked <= '0;
            terr    <= 1'b0;
        end else begin
            tcnt    <= tcnt_nxt;
            blocked <= blocked_nxt;
            terr    <= expired;
        end
    end
`else
    logic unused_timeout;
    assign req_eff        = BR;
    assign expired        = 1'b0;
    assign unused_timeout = (TIMEOUT > 0);
    assign TIMEOUT_ERR    = 1'b0;
`endif

    always_comb begin
        state_nxt    = state;
        owner_nxt    = OWNER;
        rr_last_nxt  = rr_last;
        own_oh_nxt   = own_oh;
        bg_nxt       = BG;
        dest_nxt     = '0;
        dest_idx_nxt = dest_idx;
        case (state)
            IDLE: begin
                if (win_found) begin
                    owner_nxt   = win_idx;
                    rr_last_nxt = win_idx;
                    own_oh_nxt  = win_oh;
                    bg_nxt      = win_oh;
                    state_nxt   = GRANT;
                end
            end
            GRANT: begin
                if (expired || !owner_req) begin
                    state_nxt = RELEASE;
                    bg_nxt    = '0;
                end else begin
                    state_nxt = ADDR;
                end
            end
            ADDR: begin
                // Aborted masters never get a DEST pulse.
                if (expired || !owner_req) begin
                    state_nxt = RELEASE;
                    bg_nxt    = '0;
                end else begin
                    dest_idx_nxt = A[15:14];
                    dest_nxt     = 4'b0001 << A[15:14];
                    state_nxt    = XFER;
                end
            end
            XFER: begin
                if (expired || !owner_req) begin
                    state_nxt = RELEASE;
                    bg_nxt    = '0;
                end
            end
            RELEASE: begin
                // Dead cycle so the old owner's tristate drivers turn off.
                state_nxt = IDLE;
                bg_nxt    = '0;
            end
            default: begin
                state_nxt = IDLE;
                bg_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge BUS_CLK or posedge RST) begin
        if (RST) begin
            BG       <= '0;
            DEST     <= '0;
            BUSY     <= 1'b0;
            OWNER    <= '0;
            own_oh   <= NREQ'(1);
            rr_last  <= 3'(NREQ - 1);
            dest_idx <= '0;
        end else begin
            BG       <= bg_nxt;
            DEST     <= dest_nxt;
            BUSY     <= (state_nxt != IDLE);
            OWNER    <= owner_nxt;
            own_oh   <= own_oh_nxt;
            rr_last  <= rr_last_nxt;
            dest_idx <= dest_idx_nxt;
        end
    end

    assign ack_sel  = ACK_SLV[dest_idx] && ((state == ADDR) || (state == XFER));
    assign ACK_MSTR = ack_sel ? own_oh : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus a randomized
// run compared cycle-by-cycle against a transaction-level reference model.
module tb_bus_arbiter;
    localparam int NREQ = 4;
    localparam int TO   = 8;
`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NREQ-1:0] br  = '0;
    logic [15:0]     a   = '0;
    logic [3:0]      ack = '0;
    logic [NREQ-1:0] bg, ack_m;
    logic [3:0]      dest;
    logic            busy, terr;
    logic [2:0]      owner;

    int checks = 0;
    int errors = 0;

    bus_arbiter #(.NREQ(NREQ), .TIMEOUT(TO)) dut (
        .BUS_CLK(clk), .RST(rst), .BR(br), .BG(bg), .A(a), .DEST(dest),
        .ACK_SLV(ack), .ACK_MSTR(ack_m), .BUSY(busy), .OWNER(owner),
        .TIMEOUT_ERR(terr)
    );

    always #5 clk = ~clk;

    // Reference model: mode 0 = bus free, 1 = owned, 2 = turnaround.
    // age counts owned cycles since the grant (0 grant, 1 address, 2+ data).
    int              m_mode, m_owner, m_last, m_age, m_dest_idx;
    logic [3:0]      m_dest;
    logic            m_terr;
    logic [NREQ-1:0] m_blk;

    task model_reset();
        m_mode = 0; m_owner = 0; m_last = NREQ - 1; m_age = 0; m_dest_idx = 0;
        m_dest = '0; m_terr = 1'b0; m_blk = '0;
    endtask

    task automatic model_step();
        logic [NREQ-1:0] avail;
        int w;
        m_dest = '0;
        m_terr = 1'b0;
        if (TO_EN) m_blk = m_blk & br;
        case (m_mode)
            0: begin
                avail = br & ~m_blk;
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && avail[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                if (w >= 0) begin
                    m_mode = 1; m_owner = w; m_last = w; m_age = 0;
                end
            end
            1: begin
                if (!br[m_owner]) m_mode = 2;
                else if (TO_EN && m_age == TO - 1) begin
                    m_mode = 2; m_terr = 1'b1; m_blk[m_owner] = 1'b1;
                end else begin
                    if (m_age == 1) begin
                        m_dest_idx = int'(a[15:14]);
                        m_dest     = 4'b0001 << a[15:14];
                    end
                    m_age++;
                end
            end
            default: m_mode = 0;
        endcase
    endtask

    function logic [NREQ-1:0] e_bg();
        return (m_mode == 1) ? (NREQ'(1) << m_owner) : '0;
    endfunction

    function logic [NREQ-1:0] e_ack();
        return (m_mode == 1 && m_age >= 1 && ack[m_dest_idx]) ? (NREQ'(1) << m_owner) : '0;
    endfunction

    task tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task do_reset();
        rst = 1'b1; br = '0; a = '0; ack = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task test_reset();
        rst = 1'b1; br = '0; #12;
        checks++; if (bg !== '0)    begin errors++; $display("FAIL reset_bg got %b want 0", bg); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (owner !== 3'd0) begin errors++; $display("FAIL reset_owner got %0d want 0", owner); end
        checks++; if (dest !== 4'd0) begin errors++; $display("FAIL reset_dest got %b want 0", dest); end
        checks++; if (terr !== 1'b0) begin errors++; $display("FAIL reset_terr got %b want 0", terr); end
        do_reset();
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_req busy got %b want 0", busy); end
    endtask

    task test_single();
        int dest_cnt;
        do_reset();
        br = 4'b0001; a = 16'h8000; ack = 4'b0100; dest_cnt = 0;
        for (int c = 1; c <= 7; c++) begin
            if (c == 5) br = '0;
            tick();
            if (c == 1) begin
                checks++; if (bg !== 4'b0001) begin errors++; $display("FAIL single_bg1 got %b want 0001", bg); end
            end
            if (dest !== 4'd0) begin
                dest_cnt++;
                checks++; if (dest !== 4'b0100) begin errors++; $display("FAIL single_dest got %b want 0100", dest); end
            end
            if (c == 3) begin
                checks++; if (ack_m !== 4'b0001) begin errors++; $display("FAIL single_ack got %b want 0001", ack_m); end
            end
            if (c == 6) begin
                checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle busy got %b want 0", busy); end
            end
        end
        checks++; if (dest_cnt !== 1) begin errors++; $display("FAIL single_dest_count got %0d want 1", dest_cnt); end
    endtask

    task test_round_robin();
        int ngr, gap;
        logic [NREQ-1:0] prev, want;
        do_reset();
        ngr = 0; gap = 0; prev = '0;
        for (int c = 0; c < 200 && ngr < 5; c++) begin
            br = '1;
            if (m_mode == 1 && m_age >= 4) br[m_owner] = 1'b0;
            tick();
            if (bg !== '0 && prev === '0) begin
                want = NREQ'(1) << (ngr % NREQ);
                checks++; if (bg !== want) begin errors++; $display("FAIL rr_order grant %0d got %b want %b", ngr, bg, want); end
                if (ngr > 0) begin
                    checks++; if (gap !== 2) begin errors++; $display("FAIL rr_gap grant %0d got %0d want 2", ngr, gap); end
                end
                ngr++; gap = 0;
            end else if (bg === '0) gap++;
            prev = bg;
        end
        checks++; if (ngr !== 5) begin errors++; $display("FAIL rr_grants got %0d want 5", ngr); end
        br = '0; tick(); tick();
    endtask

    task test_abort();
        do_reset();
        br = 4'b0010;
        tick();
        checks++; if (bg !== 4'b0010) begin errors++; $display("FAIL abort_bg got %b want 0010", bg); end
        br = '0;
        tick();
        checks++; if (bg !== '0 || busy !== 1'b1 || dest !== '0) begin
            errors++; $display("FAIL abort_release bg %b busy %b dest %b want 0000 1 0000", bg, busy, dest); end
        tick();
        checks++; if (busy !== 1'b0 || dest !== '0) begin
            errors++; $display("FAIL abort_idle busy %b dest %b want 0 0000", busy, dest); end
        checks++; if (owner !== 3'd1) begin errors++; $display("FAIL abort_owner got %0d want 1", owner); end
    endtask

    task test_ack_route();
        do_reset();
        br = 4'b0100; a = 16'h0040; ack = 4'b1000;
        tick(); tick(); tick();
        checks++; if (ack_m !== '0) begin errors++; $display("FAIL ack_wrong_slave got %b want 0000", ack_m); end
        ack = 4'b0001; #1;
        checks++; if (ack_m !== 4'b0100) begin errors++; $display("FAIL ack_right_slave got %b want 0100", ack_m); end
        br = '0; ack = '0; tick(); tick();
    endtask

    task test_reset_mid_xfer();
        do_reset();
        br = 4'b1000; a = 16'hC000;
        tick(); tick(); tick(); tick();
        checks++; if (bg !== 4'b1000) begin errors++; $display("FAIL midrst_pre bg got %b want 1000", bg); end
        #2; rst = 1'b1; #1;
        checks++; if (bg !== '0 || busy !== 1'b0 || dest !== '0) begin
            errors++; $display("FAIL midrst bg %b busy %b dest %b want all 0", bg, busy, dest); end
        do_reset();
    endtask

    task test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < NREQ; i++) if ($urandom_range(0, 3) == 0) br[i] = ~br[i];
            a = 16'($urandom); ack = 4'($urandom);
            tick();
            checks++; if (bg !== e_bg())     begin errors++; $display("FAIL rnd_bg cyc %0d got %b want %b", c, bg, e_bg()); end
            checks++; if (dest !== m_dest)   begin errors++; $display("FAIL rnd_dest cyc %0d got %b want %b", c, dest, m_dest); end
            checks++; if (busy !== (m_mode != 0)) begin errors++; $display("FAIL rnd_busy cyc %0d got %b", c, busy); end
            checks++; if (owner !== 3'(m_owner)) begin errors++; $display("FAIL rnd_owner cyc %0d got %0d want %0d", c, owner, m_owner); end
            checks++; if (ack_m !== e_ack())  begin errors++; $display("FAIL rnd_ack cyc %0d got %b want %b", c, ack_m, e_ack()); end
            checks++; if (terr !== m_terr)    begin errors++; $display("FAIL rnd_terr cyc %0d got %b want %b", c, terr, m_terr); end
        end
    endtask

`ifdef ARB_TIMEOUT_EN
    task test_timeout();
        int bgc, tec, b2;
        logic [NREQ-1:0] first;
        do_reset();
        br = 4'b0100; bgc = 0; tec = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            if (bg[2]) bgc++;
            if (terr) tec++;
        end
        checks++; if (bgc !== TO) begin errors++; $display("FAIL to_bg_cycles got %0d want %0d", bgc, TO); end
        checks++; if (tec !== 1)  begin errors++; $display("FAIL to_pulses got %0d want 1", tec); end
        br = 4'b0110; first = '0; b2 = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (first === '0) first = bg;
            if (bg[2]) b2++;
        end
        checks++; if (first !== 4'b0010) begin errors++; $display("FAIL to_next_owner got %b want 0010", first); end
        checks++; if (b2 !== 0) begin errors++; $display("FAIL to_locked got %0d grant cycles want 0", b2); end
        br = 4'b0010; tick();
        br = 4'b0110; first = '0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (first === '0) first = bg;
        end
        checks++; if (first !== 4'b0100) begin errors++; $display("FAIL to_regrant got %b want 0100", first); end
        br = '0; tick(); tick();
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_ack_route();
        test_reset_mid_xfer();
`ifdef ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
